// File: rtl/button_bounce_emulator_pkg.sv
// Shared types and constants for the push-button bounce emulator.
// FSM state encoding, LFSR polynomial/seed and a sizing helper.
package button_bounce_emulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_HOLD  = 3'd2,
    ST_REL   = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_bounce_emulator_lfsr16.sv
// 16-bit Galois LFSR used to randomise bounce segment lengths.
// Ports: clk, rst (async high), advance (step once), state (current value).
module lfsr16
  import button_bounce_emulator_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);

  // an all-zero seed would lock the register at zero
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = {1'b0, state_q[15:1]};
      if (state_q[0]) state_d = state_d ^ LFSR_POLY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED_EFF;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/button_bounce_emulator.sv
// Emulates one bouncy button press per start: bounce, hold, bounce, gap.
// Ports: clk, rst (async high), start -> push_button, busy, done, press_count.
module button_bounce_emulator
  import button_bounce_emulator_pkg::*;
#(
  parameter int          BOUNCE_PAIRS = 2,
  parameter int          GLITCH_MIN   = 3,
  parameter int          GLITCH_BITS  = 3,
  parameter int          RANDOM_EN    = 0,
  parameter int          HOLD_CYCLES  = 10,
  parameter int          GAP_CYCLES   = 5,
  parameter int          ACTIVE_HIGH  = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       push_button,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_count
);

  localparam int CNT_MAX = max3(
    GLITCH_MIN + (1 << GLITCH_BITS) - 1,
    HOLD_CYCLES, GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SEG_W = $clog2(2 * BOUNCE_PAIRS + 2);

  localparam logic [SEG_W-1:0] SEG_LAST =
    SEG_W'(2 * BOUNCE_PAIRS - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GLITCH_MIN - 1);
  localparam logic ACT_LVL = (ACTIVE_HIGH != 0);
  localparam logic INACT_LVL = ~ACT_LVL;
  localparam logic RND = (RANDOM_EN != 0);
  localparam logic NO_BNC = (BOUNCE_PAIRS == 0);
  localparam logic GAP_ONE = (GAP_CYCLES == 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             push_q, push_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       count_q, count_d;
  logic             adv;
  logic [15:0]      lfsr_w;
  logic [CNT_W-1:0] seg_len_m1;
  logic             unused_lfsr;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .advance(adv),
    .state  (lfsr_w)
  );

  assign unused_lfsr = ^lfsr_w;

  // length of a segment starting this cycle, minus one
  always_comb begin
    seg_len_m1 = GMIN_M1;
    if (RND) begin
      seg_len_m1 = GMIN_M1 + CNT_W'(lfsr_w[GLITCH_BITS-1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    push_d  = push_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          push_d = ACT_LVL;
          seg_d  = '0;
          if (NO_BNC) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_M1;
          end else begin
            state_d = ST_PRESS;
            cnt_d   = seg_len_m1;
            adv     = RND;
          end
        end
      end
      ST_PRESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (seg_q == SEG_LAST) begin
          state_d = ST_HOLD;
          push_d  = ACT_LVL;
          cnt_d   = HOLD_M1;
        end else begin
          seg_d  = seg_q + 1'b1;
          push_d = ~push_q;
          cnt_d  = seg_len_m1;
          adv    = RND;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push_d = INACT_LVL;
          if (NO_BNC) begin
            state_d = ST_GAP;
            cnt_d   = GAP_M1;
            done_d  = GAP_ONE;
          end else begin
            state_d = ST_REL;
            seg_d   = '0;
            cnt_d   = seg_len_m1;
            adv     = RND;
          end
        end
      end
      ST_REL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (seg_q == SEG_LAST) begin
          state_d = ST_GAP;
          push_d  = INACT_LVL;
          cnt_d   = GAP_M1;
          done_d  = GAP_ONE;
        end else begin
          seg_d  = seg_q + 1'b1;
          push_d = ~push_q;
          cnt_d  = seg_len_m1;
          adv    = RND;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          // done is registered, so raise it one cycle early
          done_d = (cnt_q == CNT_W'(1));
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        push_d  = INACT_LVL;
        busy_d  = 1'b0;
      end
    endcase
    if (done_d) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seg_q   <= '0;
      push_q  <= INACT_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      push_q  <= push_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign push_button = push_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign press_count = count_q;

endmodule
